// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: 3-point majority sampling, START/DATA/PARITY/STOP walk, LSB-first deserialise.
// Result pulses are registered, one cycle wide, at most one per frame; no backpressure (results are fire-and-forget).
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic [5:0]        prescale,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic [3:0]        bit_cnt,
    input  logic [5:0]        edge_cnt,
    output logic              cnt_enable,
    output logic [DATA_W-1:0] p_data,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic              perr;
    logic              par_en_q;
    logic              par_typ_q;
    logic [2:0]        smp;
    logic [5:0]        half;
    logic              maj;
    logic              bit_end;
    logic              stop_chk;

    assign half     = {1'b0, prescale[5:1]};
    assign bit_end  = (edge_cnt == prescale - 6'd1);
    assign stop_chk = (edge_cnt == half + 6'd2);
    assign maj      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    // Three samples around mid-bit; maj is stable from half+2 until the next bit's half-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp <= '0;
        end else begin
            if (edge_cnt == half - 6'd1) smp[0] <= rx_in;
            if (edge_cnt == half)        smp[1] <= rx_in;
            if (edge_cnt == half + 6'd1) smp[2] <= rx_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt_enable <= 1'b0;
            busy       <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            shreg      <= '0;
            perr       <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state      <= START;
                        busy       <= 1'b1;
                        cnt_enable <= 1'b1;
                        par_en_q   <= par_en;
                        par_typ_q  <= par_typ;
                        perr       <= 1'b0;
                        shreg      <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        if (maj) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            cnt_enable <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= {maj, shreg[DATA_W-1:1]};
                        if (bit_cnt == 4'(DATA_W))
                            state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        perr  <= (maj != ((^shreg) ^ par_typ_q));
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Decide early so a start edge right after the stop bit is not missed.
                    if (stop_chk) begin
                        if (!maj) begin
                            stp_err <= 1'b1;
                        end else if (perr) begin
                            par_err <= 1'b1;
                        end else begin
                            data_valid <= 1'b1;
                            p_data     <= shreg;
                        end
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cnt_enable <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cnt_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: edge/bit counter models, serial line driver, pulse scoreboards for DATA_W=8 and DATA_W=5.
module tb_uart_rx_ctrl;

    typedef struct packed {
        logic [2:0] kind;   // {data_valid, par_err, stp_err}
        logic [7:0] data;
    } exp_t;

    localparam logic [2:0] K_VAL = 3'b100;
    localparam logic [2:0] K_PAR = 3'b010;
    localparam logic [2:0] K_STP = 3'b001;

    logic       clk, rst, rx8, rx5, par_en, par_typ, sel5;
    logic [5:0] prescale;
    logic [3:0] b8, b5;
    logic [5:0] e8, e5;
    logic       ce8, ce5, dv8, dv5, pe8, pe5, se8, se5, busy8, busy5;
    logic [7:0] pd8;
    logic [4:0] pd5;
    logic [7:0] good8;
    logic       prev8, prev5;
    exp_t       q8[$];
    exp_t       q5[$];
    exp_t       x8, x5;
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_rx_ctrl #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .rx_in(rx8), .prescale(prescale), .par_en(par_en), .par_typ(par_typ),
        .bit_cnt(b8), .edge_cnt(e8), .cnt_enable(ce8), .p_data(pd8), .data_valid(dv8),
        .par_err(pe8), .stp_err(se8), .busy(busy8)
    );

    uart_rx_ctrl #(.DATA_W(5)) dut5 (
        .clk(clk), .rst(rst), .rx_in(rx5), .prescale(prescale), .par_en(par_en), .par_typ(par_typ),
        .bit_cnt(b5), .edge_cnt(e5), .cnt_enable(ce5), .p_data(pd5), .data_valid(dv5),
        .par_err(pe5), .stp_err(se5), .busy(busy5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!ce8) begin e8 <= '0; b8 <= '0; end
        else if (e8 == prescale - 6'd1) begin e8 <= '0; b8 <= b8 + 4'd1; end
        else e8 <= e8 + 6'd1;
        if (!ce5) begin e5 <= '0; b5 <= '0; end
        else if (e5 == prescale - 6'd1) begin e5 <= '0; b5 <= b5 + 4'd1; end
        else e5 <= e5 + 6'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Pulse cycle follows the check edge at prescale/2+2, so the free-running counter reads prescale/2+3.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (prev8) check("dut8 pulse width", {29'd0, dv8, pe8, se8}, 0);
            if (dv8 | pe8 | se8) begin
                if (q8.size() == 0) begin
                    check("dut8 unexpected pulse", {29'd0, dv8, pe8, se8}, 0);
                end else begin
                    x8 = q8.pop_front();
                    check("dut8 pulse kind", {29'd0, dv8, pe8, se8}, {29'd0, x8.kind});
                    check("dut8 p_data", {24'd0, pd8}, {24'd0, x8.data});
                    check("dut8 stop timing", {24'd0, busy8, ce8, e8}, {26'd0, prescale[5:1] + 6'd3});
                end
            end
            prev8 = dv8 | pe8 | se8;
            if (prev5) check("dut5 pulse width", {29'd0, dv5, pe5, se5}, 0);
            if (dv5 | pe5 | se5) begin
                if (q5.size() == 0) begin
                    check("dut5 unexpected pulse", {29'd0, dv5, pe5, se5}, 0);
                end else begin
                    x5 = q5.pop_front();
                    check("dut5 pulse kind", {29'd0, dv5, pe5, se5}, {29'd0, x5.kind});
                    check("dut5 p_data", {27'd0, pd5}, {24'd0, x5.data});
                    check("dut5 stop timing", {24'd0, busy5, ce5, e5}, {26'd0, prescale[5:1] + 6'd3});
                end
            end
            prev5 = dv5 | pe5 | se5;
        end
    end

    task automatic drive(input logic v);
        if (sel5) begin rx5 = v; rx8 = 1'b1; end
        else begin rx8 = v; rx5 = 1'b1; end
    endtask

    // Drives one frame, each bit for prescale cycles; stop_at >= 0 abandons the frame after that many cycles.
    task automatic send(input int nd, input logic [7:0] d, input bit pe, input bit pb, input bit sb, input int stop_at);
        logic [11:0] bits;
        int n;
        int p;
        p = int'(prescale);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) bits[1+i] = d[i];
        n = nd + 1;
        if (pe) begin bits[n] = pb; n++; end
        bits[n] = sb;
        n++;
        for (int c = 0; c < n * p; c++) begin
            if (stop_at >= 0 && c == stop_at) return;
            @(negedge clk);
            drive(bits[c / p]);
        end
        @(negedge clk);
        drive(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        check("dut8 idle busy", {31'd0, busy8}, 0);
        check("dut5 idle busy", {31'd0, busy5}, 0);
    endtask

    task automatic exp8(input logic [2:0] k, input logic [7:0] d);
        exp_t t;
        t.kind = k;
        t.data = d;
        q8.push_back(t);
    endtask

    task automatic exp5(input logic [2:0] k, input logic [7:0] d);
        exp_t t;
        t.kind = k;
        t.data = d;
        q5.push_back(t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rx8 = 1'b1; rx5 = 1'b1; sel5 = 1'b0;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        prev8 = 1'b0; prev5 = 1'b0; good8 = 8'h00;
        repeat (2) @(negedge clk);
        check("reset dut8 outputs", {19'd0, busy8, ce8, dv8, pe8, se8, pd8}, 0);
        check("reset dut5 outputs", {22'd0, busy5, ce5, dv5, pe5, se5, pd5}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: prescale 8, no parity
        good8 = 8'hA5; exp8(K_VAL, good8);
        send(8, 8'hA5, 0, 0, 1, -1);
        idle(24);

        // 2: prescale 16, even then odd parity
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        good8 = 8'h3C; exp8(K_VAL, good8);
        send(8, 8'h3C, 1, 0, 1, -1);
        idle(48);
        exp8(K_PAR, good8);
        send(8, 8'h3C, 1, 1, 1, -1);
        idle(48);
        par_typ = 1'b1;
        exp8(K_VAL, good8);
        send(8, 8'h3C, 1, 1, 1, -1);
        idle(48);

        // 3: start glitch, then a good frame
        par_en = 1'b0; par_typ = 1'b0;
        @(negedge clk); rx8 = 1'b0;
        repeat (3) @(negedge clk);
        rx8 = 1'b1;
        repeat (18) @(negedge clk);
        check("glitch busy", {31'd0, busy8}, 0);
        check("glitch cnt_enable", {31'd0, ce8}, 0);
        good8 = 8'h55; exp8(K_VAL, good8);
        send(8, 8'h55, 0, 0, 1, -1);
        idle(48);

        // 4: stop low with bad parity -> stop error wins
        prescale = 6'd8; par_en = 1'b1;
        exp8(K_STP, good8);
        send(8, 8'h0F, 1, 1, 0, -1);
        idle(24);

        // 5: prescale 32, back-to-back frames on both widths
        prescale = 6'd32; par_en = 1'b0;
        exp8(K_VAL, 8'h81); exp8(K_VAL, 8'h7E);
        send(8, 8'h81, 0, 0, 1, -1);
        send(8, 8'h7E, 0, 0, 1, -1);
        good8 = 8'h7E;
        idle(96);
        sel5 = 1'b1;
        exp5(K_VAL, 8'h15); exp5(K_VAL, 8'h0A);
        send(5, 8'h15, 0, 0, 1, -1);
        send(5, 8'h0A, 0, 0, 1, -1);
        idle(96);
        sel5 = 1'b0;

        // 6: reset in the middle of data bit index 4
        prescale = 6'd16;
        send(8, 8'hC3, 0, 0, 1, 4 * 16 + 8);
        check("pre-reset busy", {31'd0, busy8}, 1);
        rst = 1'b0;
        #1;
        check("async reset outputs", {19'd0, busy8, ce8, dv8, pe8, se8, pd8}, 0);
        @(negedge clk); rx8 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset counter cleared", {26'd0, e8}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        good8 = 8'hC3; exp8(K_VAL, good8);
        send(8, 8'hC3, 0, 0, 1, -1);
        idle(48);

        check("dut8 missing pulses", q8.size(), 0);
        check("dut5 missing pulses", q5.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side frame controller for the UART RX path. It gates the edge/bit counter through cnt_enable and uses the counter's bit_cnt/edge_cnt to locate each bit. It takes 3-point majority samples of rx_in and walks the frame START -> DATA -> [PARITY] -> STOP. It deserializes the data LSB-first and reports data, parity error and stop error per frame.

Parameters:
DATA_W, 8, data bits per frame; legal 5..8.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rx_in  in  1  serial line, idle high; already synchronised upstream
prescale  in  6  oversampling ratio; legal even values 8..32; must stay static while busy
par_en  in  1  parity bit present
par_typ  in  1  0 = even parity, 1 = odd parity
bit_cnt  in  4  from edge/bit counter
edge_cnt  in  6  from edge/bit counter
cnt_enable  out  1  counter enable; low clears the counter synchronously
p_data  out  DATA_W  last good frame data
data_valid  out  1  one-cycle pulse, p_data updated
par_err  out  1  one-cycle pulse, parity mismatch
stp_err  out  1  one-cycle pulse, stop bit sampled low
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, async):
  - state = IDLE; all outputs 0; shift register 0; latched config 0.
  - Takes effect immediately, including mid-frame. Counter clears on the next clk because cnt_enable=0.
- Counter contract: while cnt_enable=1, edge_cnt counts 0..prescale-1 and wraps; bit_cnt increments on each wrap. Bit index = bit_cnt:
  - 0 = start
  - 1..DATA_W = data
  - DATA_W+1 = parity (when enabled)
  - next index = stop
- Sampler:
  - Registers rx_in at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1.
  - maj = majority of the three samples, valid from edge_cnt = prescale/2+2 on.
  - "bit end" = edge_cnt == prescale-1.
- FSM:
  - IDLE: cnt_enable=0. When rx_in=0 at a clk edge: go to START, cnt_enable=1 from the next cycle. At the same edge, latch par_en and par_typ; these latched values govern the whole frame.
  - START: at bit end, maj=1 is a glitch: go to IDLE, cnt_enable=0, no pulses. Otherwise go to DATA.
  - DATA: at bit end, shift maj in at the MSB and shift right (LSB-first). At bit end with bit_cnt==DATA_W: go to PARITY if latched par_en, else STOP.
  - PARITY: at bit end, compute expected parity = XOR of the shifted data, inverted when par_typ=1. Set the internal perr flag if maj != expected. Go to STOP.
  - STOP: at edge_cnt == prescale/2+2 (no wait for bit end, so an immediately following start edge is caught):
    - maj=0: stp_err=1.
    - else if perr: par_err=1.
    - else: data_valid=1 and p_data <= shift register.
    - In every case go to IDLE and drop cnt_enable on the next cycle.
- Pulses are exactly one clk wide and registered. At most one of data_valid, par_err, stp_err fires per frame; stp_err takes priority over par_err.
- p_data holds its value until the next good frame; errored frames leave it unchanged.
- perr and the shift register clear on IDLE -> START.
- rx_in low while in IDLE on the cycle after STOP exits: treated as a new start edge.
- Prescale outside the legal range, or changed while busy: undefined; no checks required.

Test Plan:
1. prescale=8, par_en=0, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> exactly one data_valid, p_data=0xA5, no error pulses. data_valid fires at edge_cnt=6 of the stop bit; busy drops the next cycle.
2. prescale=16, par_en=1, par_typ=0, send 0x3C with parity bit 0 -> data_valid, p_data=0x3C. Repeat with parity bit 1 -> par_err pulse, no data_valid, p_data stays 0x3C. Repeat with par_typ=1 and parity bit 1 -> valid.
3. prescale=16, rx_in low for 3 cycles then high -> FSM returns to IDLE at start bit end, cnt_enable low, no pulses. A following valid frame of 0x55 is received correctly.
4. prescale=8, send 0x0F with stop bit 0 (par_en=1, parity also wrong) -> stp_err pulse only; no par_err, no data_valid.
5. prescale=32, frames 0x81 then 0x7E, second start edge one cycle after the first stop bit ends -> two data_valid pulses, values 0x81 then 0x7E, no errors. Repeat with DATA_W=5 and 0x15.
6. Assert rst during DATA bit 4 -> all outputs 0 and busy=0 immediately, cnt_enable=0. After release, frame 0xC3 is received correctly.
